if_pc_gen: RTL

Instruction-fetch PC generator: holds the fetch PC, selects the next PC (sequential, branch/jump redirect, interrupt vector, exception return) and runs the interrupt-entry state machine. It sits directly upstream of the IF/ID pipeline register. It supplies the fetch address to instruction memory, supplies PC+4 to IF/ID, and drives the IF/ID zero/flush input when an interrupt is taken. The pipeline has no branch delay slot; redirects come from ID or later.

---
 rtl/if_pc_gen.sv | 136 +++++++++++++
 1 files changed

// File: rtl/if_pc_gen.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// if_pc_gen -- instruction-fetch PC generator
//
// Holds the fetch PC and picks the next one. The choices, highest priority
// first, are: exception return, interrupt vector, downstream redirect,
// sequential +4, and hold. It also runs the interrupt-entry FSM and squashes
// IF/ID when an interrupt is taken.
//
// Optional feature macro: IF_PC_GEN_INT_EN
//   defined   : interrupt FSM and epc register are built.
//   undefined : int_req is ignored, epc/in_isr/flush/int_taken are tied to 0,
//               and eret redirects to address 0.
//
// Ports
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   en               fetch advances (0 = stall)
//   redirect         taken branch/jump, target on redirect_pc
//   eret             exception return committing (one-cycle pulse)
//   int_req          external interrupt request (one-cycle pulse)
//   pc               current fetch address
//   pc_plus4         pc + 4, modulo 2^PC_BITS
//   epc              saved return address
//   flush            zero IF/ID on the next edge (interrupt taken)
//   in_isr           handler active
//   int_taken        pulse in the cycle the vector is selected
// ---------------------------------------------------------------------------
module if_pc_gen #(
    parameter int unsigned        PC_BITS    = 32,
    parameter logic [PC_BITS-1:0] RESET_PC   = '0,
    parameter logic [PC_BITS-1:0] INT_VECTOR = PC_BITS'(32'h0000_0800)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               redirect,
    input  logic [PC_BITS-1:0] redirect_pc,
    input  logic               eret,
    input  logic               int_req,
    output logic [PC_BITS-1:0] pc,
    output logic [PC_BITS-1:0] pc_plus4,
    output logic [PC_BITS-1:0] epc,
    output logic               flush,
    output logic               in_isr,
    output logic               int_taken
);

    logic [PC_BITS-1:0] pc_q, pc_d;
    logic [PC_BITS-1:0] eret_pc;   // where eret returns to
    logic               take;      // interrupt vector selected this cycle

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + PC_BITS'(32'd4);

`ifdef IF_PC_GEN_INT_EN
    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_PEND       = 2'd1,
        S_SERVE      = 2'd2,
        S_SERVE_PEND = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [PC_BITS-1:0] epc_q, epc_d;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:       if (int_req) state_d = S_PEND;
            // A pending request is held until it can be taken.
            S_PEND:       if (take) state_d = S_SERVE;
            S_SERVE: begin
                if (eret && int_req) state_d = S_PEND;
                else if (eret)       state_d = S_IDLE;
                else if (int_req)    state_d = S_SERVE_PEND;
            end
            // Extra requests while one is already queued are merged.
            S_SERVE_PEND: if (eret) state_d = S_PEND;
            default:      state_d = S_IDLE;
        endcase
    end

    // Output logic. The take yields to any redirect or eret that is already
    // in flight, and to a stall, so the PC it saves is the one really in IF.
    always_comb begin
        take      = (state_q == S_PEND) && en && !redirect && !eret;
        flush     = take;
        int_taken = take;
        in_isr    = (state_q == S_SERVE) || (state_q == S_SERVE_PEND);
    end

    // The instruction in IF is squashed on take, so it is the one refetched
    // after eret.
    assign epc_d = take ? pc_q : epc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) epc_q <= '0;
        else     epc_q <= epc_d;
    end

    assign epc     = epc_q;
    assign eret_pc = epc_q;
`else
    logic unused_int_req;
    assign unused_int_req = int_req;

    assign take      = 1'b0;
    assign flush     = 1'b0;
    assign int_taken = 1'b0;
    assign in_isr    = 1'b0;
    assign epc       = '0;
    assign eret_pc   = '0;
`endif

    // Next-PC select
    always_comb begin
        pc_d = pc_q;
        if (eret)          pc_d = eret_pc;
        else if (take)     pc_d = INT_VECTOR;
        else if (redirect) pc_d = redirect_pc;
        else if (en)       pc_d = pc_plus4;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

endmodule
